// File: rtl/bcd_display_mux.sv
// Four-digit multiplexed 7-segment driver for BCD counter chains.
// Frame-synchronous shadow capture keeps a scan tear-free; optional leading-zero blanking.
module bcd_display_mux #(
  parameter int unsigned REFRESH_DIV = 4,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned     PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]   PRE_ZERO = {PW{1'b0}};

  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shd_q, shd_d;
  logic [3:0]    sdp_q, sdp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;

  logic [3:0]    cur_nib_s;
  logic          blank_s;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Select the shadow nibble for the active digit and decide whether it is a leading zero.
  always_comb begin
    cur_nib_s = 4'd0;
    blank_s   = 1'b0;
    case (idx_q)
      2'd0: begin
        cur_nib_s = shd_q[3:0];
        blank_s   = 1'b0;
      end
      2'd1: begin
        cur_nib_s = shd_q[7:4];
        blank_s   = BLANK_LZ && (shd_q[15:4] == 12'd0);
      end
      2'd2: begin
        cur_nib_s = shd_q[11:8];
        blank_s   = BLANK_LZ && (shd_q[15:8] == 8'd0);
      end
      2'd3: begin
        cur_nib_s = shd_q[15:12];
        blank_s   = BLANK_LZ && (shd_q[15:12] == 4'd0);
      end
      default: begin
        cur_nib_s = 4'd0;
        blank_s   = 1'b0;
      end
    endcase
  end

  // Next-state: prescaler, digit index, frame-start shadow load and output encoding.
  always_comb begin
    pre_d = pre_q;
    idx_d = idx_q;
    shd_d = shd_q;
    sdp_d = sdp_q;
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    fd_d  = 1'b0;
    if (en) begin
      if (pre_q == PRE_MAX) begin
        pre_d = PRE_ZERO;
        idx_d = idx_q + 2'd1;
        fd_d  = (idx_q == 2'd3);
      end else begin
        pre_d = pre_q + PW'(1);
      end
      // Outputs use the shadow as it stood before this cycle's load.
      if ((idx_q == 2'd0) && (pre_q == PRE_ZERO)) begin
        shd_d = digits;
        sdp_d = dp_in;
      end else begin
        shd_d = shd_q;
        sdp_d = sdp_q;
      end
      an_d = ~(4'b0001 << idx_q);
      if (blank_s) begin
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
      end else begin
        seg_d = bcd_to_seg(cur_nib_s);
        dp_d  = ~sdp_q[idx_q];
      end
    end else begin
      fd_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= PRE_ZERO;
      idx_q <= 2'd0;
      shd_q <= 16'd0;
      sdp_q <= 4'd0;
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      shd_q <= shd_d;
      sdp_q <= sdp_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fd_q  <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Scoreboard bench: default instance (div 4, blanking on) and a div-1, no-blanking instance
// share stimulus; a reference model pushes expected outputs, compared after each edge.
module tb_bcd_display_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, fd0, fd1;

  int n_vec = 0;
  int n_err = 0;
  int fd_cnt0, fd_cnt1;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } out_t;

  typedef struct packed {
    out_t a;
    out_t b;
  } exp_t;

  exp_t sb[$];

  logic [6:0] seg_tab [0:15] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                                 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  int         m_pre [2];
  int         m_idx [2];
  logic [15:0] m_sh [2];
  logic [3:0] m_sdp [2];
  out_t       m_out [2];

  bcd_display_mux #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_in(dp_in),
    .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0)
  );

  bcd_display_mux #(.REFRESH_DIV(1), .BLANK_LZ(1'b0)) dut_fast (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_in(dp_in),
    .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour of one instance for the coming rising edge.
  task automatic model_step(input int k, input int div, input bit blz);
    logic [15:0] upper;
    logic        blank;
    if (rst) begin
      m_pre[k] = 0;
      m_idx[k] = 0;
      m_sh[k]  = 16'd0;
      m_sdp[k] = 4'd0;
      m_out[k] = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, fd: 1'b0};
    end else if (en) begin
      upper = m_sh[k] >> (4 * m_idx[k]);
      blank = blz && (m_idx[k] != 0) && (upper == 16'd0);
      m_out[k].an  = 4'b1111;
      m_out[k].an[m_idx[k]] = 1'b0;
      m_out[k].seg = blank ? 7'b1111111 : seg_tab[upper[3:0]];
      m_out[k].dp  = blank ? 1'b1 : !m_sdp[k][m_idx[k]];
      m_out[k].fd  = (m_idx[k] == 3) && (m_pre[k] == div - 1);
      if (m_idx[k] == 0 && m_pre[k] == 0) begin
        m_sh[k]  = digits;
        m_sdp[k] = dp_in;
      end
      if (m_pre[k] == div - 1) begin
        m_pre[k] = 0;
        m_idx[k] = (m_idx[k] + 1) % 4;
      end else begin
        m_pre[k] = m_pre[k] + 1;
      end
    end else begin
      m_out[k].fd = 1'b0;
    end
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      model_step(0, 4, 1'b1);
      model_step(1, 1, 1'b0);
      sb.push_back('{a: m_out[0], b: m_out[1]});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_val("an",       32'(an0),  32'(e.a.an));
      check_val("seg",      32'(seg0), 32'(e.a.seg));
      check_val("dp",       32'(dp0),  32'(e.a.dp));
      check_val("fd",       32'(fd0),  32'(e.a.fd));
      check_val("fast_an",  32'(an1),  32'(e.b.an));
      check_val("fast_seg", 32'(seg1), 32'(e.b.seg));
      check_val("fast_dp",  32'(dp1),  32'(e.b.dp));
      check_val("fast_fd",  32'(fd1),  32'(e.b.fd));
      fd_cnt0 += int'(fd0);
      fd_cnt1 += int'(fd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_an"},  32'(an0),  32'(4'b1111));
    check_val({tag, "_seg"}, 32'(seg0), 32'(7'b1111111));
    check_val({tag, "_dp"},  32'(dp0),  32'(1'b1));
    check_val({tag, "_fd"},  32'(fd0),  32'(1'b0));
    check_val({tag, "_fast_an"}, 32'(an1), 32'(4'b1111));
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    digits = 16'h0000;
    dp_in  = 4'b0000;
    #1;
    check_reset_outputs("por");
    step(2);

    // Scan after release: first cycle shows the still-empty shadow.
    rst     = 1'b0;
    en      = 1'b1;
    digits  = 16'h1234;
    fd_cnt0 = 0;
    fd_cnt1 = 0;
    step(1);
    check_val("first_an",  32'(an0),  32'(4'b1110));
    check_val("first_seg", 32'(seg0), 32'(7'b1000000));
    step(1);
    check_val("second_seg", 32'(seg0), 32'(7'b0011001));
    step(62);
    check_val("fd_count",      32'(fd_cnt0), 32'd4);
    check_val("fast_fd_count", 32'(fd_cnt1), 32'd16);

    // Tear-free load: change inputs while digit 1 is on display.
    step(4);
    digits = 16'h9876;
    step(28);

    // Freeze mid-digit, then resume.
    step(2);
    en = 1'b0;
    step(10);
    en = 1'b1;
    step(20);

    // Decimal point and blanking / dash patterns.
    dp_in = 4'b0100;
    step(32);
    dp_in  = 4'b0000;
    digits = 16'h0005;
    step(32);
    digits = 16'h0000;
    step(32);
    digits = 16'h00A0;
    step(32);
    digits = 16'hF10B;
    step(32);

    // Random traffic with enable dropouts.
    for (int i = 0; i < 300; i++) begin
      digits = 16'($urandom);
      dp_in  = 4'($urandom);
      en     = ($urandom_range(0, 3) != 0);
      step(1);
    end

    // Asynchronous reset mid-scan, between clock edges.
    en     = 1'b1;
    digits = 16'h0708;
    step(7);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    step(3);
    rst = 1'b0;
    step(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
